// File: rtl/sprite_table_arbiter_pkg.sv
// Shared constants, requester IDs, FSM state type and entry field helpers
// for the sprite attribute table and its arbiter.
package sprite_table_arbiter_pkg;

    localparam int SPRITE_ADDR_W        = 5;
    localparam int SPRITE_DATA_W        = 20;
    localparam int SPRITE_WINDOW_CYCLES = 512;
    localparam int SPRITE_NUM_REQ       = 3;

    localparam int REQ_PLAYER = 0;
    localparam int REQ_ALIEN  = 1;
    localparam int REQ_BULLET = 2;

    localparam int X_LSB = 0;
    localparam int Y_LSB = 10;
    localparam int POS_W = 10;

    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } arb_state_e;

    function automatic logic [POS_W-1:0] sprite_x(input logic [SPRITE_DATA_W-1:0] entry);
        return entry[X_LSB +: POS_W];
    endfunction

    function automatic logic [POS_W-1:0] sprite_y(input logic [SPRITE_DATA_W-1:0] entry);
        return entry[Y_LSB +: POS_W];
    endfunction

    function automatic logic [SPRITE_DATA_W-1:0] sprite_pack(input logic [POS_W-1:0] y,
                                                             input logic [POS_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/sprite_table_arbiter_picker.sv
// rr_priority_picker: combinational round-robin one-hot picker; the first
// unmasked request at or after ptr wins, wrapping modulo N.
module rr_priority_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             valid
);

    logic [N-1:0] eligible;
    logic [N-1:0] rot;

    assign eligible = req & ~mask;
    // Rotate so that bit 0 of rot is the requester the pointer designates.
    assign rot = N'({eligible, eligible} >> ptr);

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int s;
        win   = '0;
        valid = 1'b0;
        s     = 0;
        for (int off = 0; off < N; off++) begin
            if (!valid && rot[off]) begin
                valid = 1'b1;
                s     = int'(ptr) + off;
                if (s >= N) s = s - N;
                win[PTR_W'(s)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_table_arbiter.sv
// sprite_table_arbiter: scanner owns the sprite RAM outside the vblank update
// window; inside it, game requesters share it round-robin. Define ARB_STATS_EN for miss_cnt.
module sprite_table_arbiter
    import sprite_table_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = SPRITE_NUM_REQ,
    parameter int ADDR_W        = SPRITE_ADDR_W,
    parameter int DATA_W        = SPRITE_DATA_W,
    parameter int WINDOW_CYCLES = SPRITE_WINDOW_CYCLES
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      update,
    input  logic                      scan_en,
    input  logic [ADDR_W-1:0]         scan_addr,
    output logic [DATA_W-1:0]         scan_rdata,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
`ifdef ARB_STATS_EN
    output logic [7:0]                miss_cnt,
`endif
    output logic                      window_open,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);

    arb_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [PTR_W-1:0]    ptr;
    logic                gnt_we;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;
    logic [NUM_REQ-1:0]  win;
    logic                win_valid;
    logic [PTR_W-1:0]    win_idx;
    logic                pick;
    logic                closing;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req),
        .mask  (gnt),
        .ptr   (ptr),
        .win   (win),
        .valid (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    // The final open cycle (cnt == 0) never picks, so no grant lands in a closed cycle.
    assign pick        = (state == ST_OPEN) && (cnt != '0) && win_valid;
    assign closing     = (state == ST_OPEN) && (cnt == '0) && !update;
    assign window_open = (state == ST_OPEN);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state     <= ST_CLOSED;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            gnt_we    <= 1'b0;
            gnt_addr  <= '0;
            gnt_wdata <= '0;
        end else begin
            rvalid <= gnt_we ? '0 : gnt;
            gnt    <= '0;
            gnt_we <= 1'b0;
            case (state)
                ST_CLOSED: begin
                    if (update) begin
                        state <= ST_OPEN;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_OPEN: begin
                    if (update)       cnt   <= CNT_LOAD;
                    else if (closing) state <= ST_CLOSED;
                    else              cnt   <= cnt - 1'b1;
                    if (pick) begin
                        gnt       <= win;
                        gnt_we    <= req_we[win_idx];
                        gnt_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                        gnt_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        ptr       <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                default: state <= ST_CLOSED;
            endcase
        end
    end

    // An outstanding grant keeps the RAM even across the close; the scanner
    // only drives it while closed with nothing in flight.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = scan_addr;
        mem_wdata = gnt_wdata;
        if (|gnt) begin
            mem_en   = 1'b1;
            mem_we   = gnt_we;
            mem_addr = gnt_addr;
        end else if (state == ST_CLOSED) begin
            mem_en = scan_en;
        end
    end

    assign scan_rdata = mem_rdata;
    assign rdata      = mem_rdata;

`ifdef ARB_STATS_EN
    logic [8:0] miss_sum;
    assign miss_sum = {1'b0, miss_cnt} + 9'($countones(req));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            miss_cnt <= '0;
        end else if ((state == ST_CLOSED) && update) begin
            miss_cnt <= '0;
        end else if (closing) begin
            miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
        end
    end
`endif

endmodule

// File: doc/sprite_table_arbiter.md
Name: sprite_table_arbiter

Overview:
Shares the single-port sprite attribute RAM (per-object x/y position words) between the VGA pixel scanner and the game-logic requesters (player, alien block, bullets).
- Scanner owns the RAM outside the vertical-blank update window, with absolute priority.
- Game requesters are served round-robin, one access per cycle, only inside the window.
- The window is opened by the `update` pulse from vga_timings.

Parameters:
NUM_REQ, 3, number of game-logic requesters
ADDR_W, 5, sprite table address width (32 entries)
DATA_W, 20, entry width ({y[9:0], x[9:0]})
WINDOW_CYCLES, 512, clk cycles the update window stays open after an `update` pulse

Ports:
clk  in  1  system clock
arst  in  1  asynchronous active-low reset
update  in  1  one-cycle pulse at start of vblank (from vga_timings)
scan_en  in  1  scanner read enable
scan_addr  in  ADDR_W  scanner read address
scan_rdata  out  DATA_W  scanner read data, 1 cycle after scan_en
req  in  NUM_REQ  per-requester access request (level)
req_we  in  NUM_REQ  per-requester write (1) / read (0)
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
gnt  out  NUM_REQ  one-hot grant pulse
rvalid  out  NUM_REQ  one-hot read-data-valid pulse
rdata  out  DATA_W  read data for rvalid requester
window_open  out  1  update window active
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency

Behaviour:
- **Reset** (arst low, async): window_open=0, gnt=0, rvalid=0, mem_we=0, window counter=0, round-robin pointer=0. rdata and scan_rdata are don't-care but driven.
- **States:** CLOSED, OPEN.
  - CLOSED→OPEN on `update`: counter loads WINDOW_CYCLES-1, window_open=1 from the next cycle.
  - OPEN: counter decrements each cycle. OPEN→CLOSED when the counter is 0.
  - `update` while OPEN reloads the counter and extends the window.
- **CLOSED:**
  - mem_en=scan_en, mem_addr=scan_addr, mem_we=0, combinational pass-through.
  - scan_rdata=mem_rdata.
  - Game requests are held pending and no gnt is issued.
- **OPEN:**
  - Scanner accesses are ignored: mem_en does not follow scan_en, and scan_rdata is stale.
  - Each cycle, pick the first asserted req starting at the pointer, wrapping modulo NUM_REQ.
  - **Masking:** a requester whose gnt is high in the current cycle is excluded from that cycle's pick.
  - **Grant registration:** the winner's gnt is registered and high in the next cycle. In that same cycle mem_en=1, mem_we=req_we[i], mem_addr/mem_wdata are registered copies of the winner's inputs.
  - After each grant the pointer becomes winner+1, wrapping.
- **Grant rules:**
  - At most one gnt per cycle.
  - The requester must hold req/addr/data/we stable until gnt.
  - The requester drops req in the gnt cycle, or re-asserts it for a new access.
  - Deasserting req before gnt withdraws the request with no access.
- **Reads:** rvalid[i]=1 and rdata=mem_rdata one cycle after the gnt cycle. Writes produce no rvalid.
- **Window close:**
  - No pick occurs in the final OPEN cycle (counter==0).
  - A gnt/rvalid already in flight completes across the close. The RAM is still owned by the arbiter for that cycle, and the scanner gets the RAM from the first cycle in which no grant is outstanding.
- **Reset mid-window:** window closes immediately, in-flight gnt/rvalid are dropped, and no partial write is issued after reset asserts.

Optional Feature:
Macro: ARB_STATS_EN.
- **Defined:** adds output `miss_cnt` [7:0].
  - At each OPEN→CLOSED transition, add the popcount of `req` in that cycle, saturating at 255.
  - Cleared on reset and on each CLOSED→OPEN transition.
  - Reports requesters starved by a too-short window.
- **Undefined:** port and logic are absent; no other behavioural change.

Decomposition:
- **Shared package / constants include:**
  - SPRITE_ADDR_W, SPRITE_DATA_W, SPRITE_WINDOW_CYCLES.
  - Requester IDs: REQ_PLAYER=0, REQ_ALIEN=1, REQ_BULLET=2.
  - Field slices: X at [9:0], Y at [19:10].
- **Sub-module:** rr_priority_picker, a combinational round-robin one-hot picker (req, mask, pointer → one-hot winner, valid).

Test Plan:
- **Scanner pass-through:** window closed, scan_en=1, scan_addr=7, RAM[7]=0x0A064 → mem_addr=7, mem_we=0, scan_rdata=0x0A064 next cycle; gnt stays 0 with req=3'b111.
- **Window timing:** WINDOW_CYCLES=8, pulse `update` → window_open high exactly 8 cycles, then low.
- **Round-robin:** all three reads held continuously, pointer=0 → gnt order 001,010,100,001,… one per cycle. rvalid follows each gnt by 1 cycle with the correct RAM data.
- **Write then read:** requester 1 writes addr 3 = 0x12345, then reads addr 3 → mem_we=1 in the gnt cycle. rdata=0x12345 with rvalid=010.
- **Close boundary:** req[2] asserted on the last OPEN cycle → no gnt, request pending until the next `update`. With ARB_STATS_EN, miss_cnt=1.
- **Async reset mid-window:** arst low during a gnt cycle → gnt, rvalid, window_open drop immediately. After release, the first gnt goes to requester 0.
